// File: rtl/fe_twm_pkg.sv
// Shared constants, twiddle tables and helper functions for the FE twiddle multiplier.
package fe_twm_pkg;

    localparam logic IDX_I = 1'b0;
    localparam logic IDX_Q = 1'b1;
    localparam int   CS_W  = 8;

    typedef struct packed {
        logic signed [CS_W:0] c;
        logic signed [CS_W:0] s;
    } cs_t;

    // {cos, sin} * 128 rounded, first quadrant, NS = 16
    function automatic logic [2*CS_W-1:0] rom16(input logic [1:0] off);
        case (off)
            2'd1:    return {8'd118, 8'd49};
            2'd2:    return {8'd91,  8'd91};
            2'd3:    return {8'd49,  8'd118};
            default: return {8'd127, 8'd0};
        endcase
    endfunction

    function automatic logic [2*CS_W-1:0] rom64(input logic [3:0] off);
        case (off)
            4'd1:    return {8'd127, 8'd13};
            4'd2:    return {8'd126, 8'd25};
            4'd3:    return {8'd122, 8'd37};
            4'd4:    return {8'd118, 8'd49};
            4'd5:    return {8'd113, 8'd60};
            4'd6:    return {8'd106, 8'd71};
            4'd7:    return {8'd99,  8'd81};
            4'd8:    return {8'd91,  8'd91};
            4'd9:    return {8'd81,  8'd99};
            4'd10:   return {8'd71,  8'd106};
            4'd11:   return {8'd60,  8'd113};
            4'd12:   return {8'd49,  8'd118};
            4'd13:   return {8'd37,  8'd122};
            4'd14:   return {8'd25,  8'd126};
            4'd15:   return {8'd13,  8'd127};
            default: return {8'd127, 8'd0};
        endcase
    endfunction

    // e = bitrev_lr(cnt / R) * (cnt % R) mod R*R, with R = 2^lr
    function automatic logic [5:0] tw_exp(input logic [5:0] cnt, input int lr);
        logic [5:0] hi, dig, rev, prod;
        hi  = cnt >> lr;
        dig = cnt & ((6'd1 << lr) - 6'd1);
        rev = '0;
        for (int b = 0; b < 3; b++)
            if (b < lr) rev[3'(lr - 1 - b)] = hi[3'(b)];
        prod = rev * dig;
        return prod & ((6'd1 << (2 * lr)) - 6'd1);
    endfunction

    function automatic cs_t rot_quad(input logic signed [CS_W-1:0] c,
                                     input logic signed [CS_W-1:0] s,
                                     input logic [1:0] q, input logic inv);
        cs_t r;
        logic signed [CS_W:0] ce, se;
        ce = {c[CS_W-1], c};
        se = {s[CS_W-1], s};
        case (q)
            2'd1:    begin r.c = -se; r.s = ce;  end
            2'd2:    begin r.c = -ce; r.s = -se; end
            2'd3:    begin r.c = se;  r.s = -ce; end
            default: begin r.c = ce;  r.s = se;  end
        endcase
        if (inv) r.s = -r.s;
        return r;
    endfunction

endpackage

// File: rtl/fe_tw_rom.sv
// Registered first-quadrant twiddle ROM: offset -> {cos, sin}, table chosen by NS.
module fe_tw_rom
    import fe_twm_pkg::*;
#(
    parameter int NS = 16,
    parameter int OW = 2
) (
    input  logic                   clk,
    input  logic                   i_en,
    input  logic [OW-1:0]          i_off,
    output logic signed [CS_W-1:0] o_c,
    output logic signed [CS_W-1:0] o_s
);
    logic [2*CS_W-1:0] w_word;

    always_comb begin
        w_word = (NS == 64) ? rom64(4'(i_off)) : rom16(i_off[1:0]);
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            o_c <= w_word[2*CS_W-1:CS_W];
            o_s <= w_word[CS_W-1:0];
        end
    end
endmodule

// File: rtl/rnd_sat.sv
// Fixed-point reduction: round (half-up, or half-away-from-zero when RND_INF) then symmetric saturate.
module rnd_sat #(
    parameter int NBW_IN  = 17,
    parameter int NBI_IN  = 3,
    parameter int NBW_OUT = 8,
    parameter int NBI_OUT = 1,
    parameter int RND_INF = 0
) (
    input  logic [NBW_IN-1:0]  i_data,
    output logic [NBW_OUT-1:0] o_data
);
    localparam int SH = (NBW_IN - NBI_IN) - (NBW_OUT - NBI_OUT);
    localparam int RW = NBW_IN + 1;
    localparam logic signed [RW-1:0] HALF = RW'(2 ** (SH - 1));
    localparam logic signed [RW-1:0] MAXV = RW'(2 ** (NBW_OUT - 1) - 1);
    localparam logic signed [RW-1:0] MINV = -MAXV;

    logic signed [RW-1:0] w_ext, w_bias, w_sum, w_sh;

    always_comb begin
        w_ext  = $signed({i_data[NBW_IN-1], i_data});
        w_bias = HALF;
        if (RND_INF != 0 && w_ext[RW-1]) w_bias = HALF - RW'(1);
        w_sum  = w_ext + w_bias;
        w_sh   = w_sum >>> SH;
        if (w_sh > MAXV)      o_data = MAXV[NBW_OUT-1:0];
        else if (w_sh < MINV) o_data = MINV[NBW_OUT-1:0];
        else                  o_data = w_sh[NBW_OUT-1:0];
    end
endmodule

// File: rtl/fe_twm_pipe.sv
// Runtime-indexed complex twiddle multiplier y = x * W_NS^e (or its conjugate),
// four stages: exponent capture, ROM read, multiply, round/saturate into the output register.
module fe_twm_pipe
    import fe_twm_pkg::*;
#(
    parameter int NS      = 16,
    parameter int NBW_IN  = 8,
    parameter int NBI_IN  = 1,
    parameter int NBW_OUT = 8,
    parameter int NBI_OUT = 1,
    parameter int NBW_CS  = 8,
    parameter int IDX_EXT = 0,
    parameter int RND_INF = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic                      i_sof,
    input  logic [$clog2(NS)-1:0]     i_idx,
    input  logic                      i_inv,
    input  logic [1:0][NBW_IN-1:0]    i_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_sof,
    output logic [1:0][NBW_OUT-1:0]   o_data
);
    localparam int EW      = $clog2(NS);
    localparam int LR      = EW / 2;
    localparam int OW      = EW - 2;
    localparam int NBW_P   = NBW_IN + NBW_CS + 1;
    localparam int NBI_P   = NBI_IN + 2;
    localparam int FRAC_CS = NBW_CS - 1;

    // Handshake: input transfers on i_valid & o_ready, output is consumed on o_valid & i_ready;
    // all stages advance together whenever the output register is empty or being drained.
    logic w_en, w_xfer;
    assign w_en    = ~o_valid | i_ready;
    assign o_ready = w_en;
    assign w_xfer  = i_valid & w_en;

    logic [EW-1:0] r_cnt, w_cnt_cur, w_e_cnt, w_e;
    assign w_cnt_cur = i_sof ? '0 : r_cnt;
    assign w_e_cnt   = EW'(tw_exp(6'(w_cnt_cur), LR));
    assign w_e       = (IDX_EXT != 0) ? i_idx : w_e_cnt;

    logic                   r1_valid, r2_valid, r3_valid;
    logic                   r1_sof, r2_sof, r3_sof, r1_inv, r2_inv, r2_byp;
    logic [1:0][NBW_IN-1:0] r1_x, r2_x;
    logic [EW-1:0]          r1_e;
    logic [1:0]             r2_q;
    logic [1:0][NBW_P-1:0]  r3_p;

    logic signed [CS_W-1:0]  w_rom_c, w_rom_s;
    cs_t                     w_cs;
    logic signed [NBW_P-1:0] w_xi, w_xq, w_ci, w_si, w_mul_i, w_mul_q, w_by_i, w_by_q;
    logic [NBW_OUT-1:0]      w_rs_i, w_rs_q;

    fe_tw_rom #(.NS(NS), .OW(OW)) u_rom (
        .clk(clk), .i_en(w_en), .i_off(r1_e[OW-1:0]), .o_c(w_rom_c), .o_s(w_rom_s)
    );

    assign w_cs    = rot_quad(w_rom_c, w_rom_s, r2_q, r2_inv);
    assign w_xi    = NBW_P'($signed(r2_x[IDX_I]));
    assign w_xq    = NBW_P'($signed(r2_x[IDX_Q]));
    assign w_ci    = NBW_P'($signed(w_cs.c));
    assign w_si    = NBW_P'($signed(w_cs.s));
    assign w_mul_i = w_xi * w_ci + w_xq * w_si;
    assign w_mul_q = w_xq * w_ci - w_xi * w_si;

    // Multiples of 90 degrees: swap/negate only, scaled to the product's binary point
    always_comb begin
        w_by_i = w_xi;
        w_by_q = w_xq;
        case (r2_q)
            2'd1:    begin w_by_i = r2_inv ? -w_xq : w_xq;  w_by_q = r2_inv ? w_xi : -w_xi; end
            2'd2:    begin w_by_i = -w_xi;                  w_by_q = -w_xq;                 end
            2'd3:    begin w_by_i = r2_inv ? w_xq : -w_xq;  w_by_q = r2_inv ? -w_xi : w_xi; end
            default: ;
        endcase
    end

    rnd_sat #(.NBW_IN(NBW_P), .NBI_IN(NBI_P), .NBW_OUT(NBW_OUT), .NBI_OUT(NBI_OUT),
              .RND_INF(RND_INF)) u_rs_i (.i_data(r3_p[IDX_I]), .o_data(w_rs_i));
    rnd_sat #(.NBW_IN(NBW_P), .NBI_IN(NBI_P), .NBW_OUT(NBW_OUT), .NBI_OUT(NBI_OUT),
              .RND_INF(RND_INF)) u_rs_q (.i_data(r3_p[IDX_Q]), .o_data(w_rs_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r1_valid <= 1'b0;
            r2_valid <= 1'b0;
            r3_valid <= 1'b0;
            o_valid  <= 1'b0;
            o_sof    <= 1'b0;
            o_data   <= '0;
        end else if (w_en) begin
            if (w_xfer) r_cnt <= w_cnt_cur + 1'b1;
            r1_valid <= i_valid;
            r2_valid <= r1_valid;
            r3_valid <= r2_valid;
            o_valid  <= r3_valid;
            o_sof    <= r3_valid & r3_sof;
            if (r3_valid) begin
                o_data[IDX_I] <= w_rs_i;
                o_data[IDX_Q] <= w_rs_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            r1_sof <= i_sof;
            r1_inv <= i_inv;
            r1_x   <= i_data;
            r1_e   <= w_e;
            r2_sof <= r1_sof;
            r2_inv <= r1_inv;
            r2_x   <= r1_x;
            r2_q   <= r1_e[EW-1:EW-2];
            r2_byp <= (r1_e[OW-1:0] == '0);
            r3_sof <= r2_sof;
            r3_p[IDX_I] <= r2_byp ? (w_by_i <<< FRAC_CS) : w_mul_i;
            r3_p[IDX_Q] <= r2_byp ? (w_by_q <<< FRAC_CS) : w_mul_q;
        end
    end
endmodule

// File: tb/tb_fe_twm_pipe.sv
// Directed bench for fe_twm_pipe: one instance with external index, one with the frame counter.
module tb_fe_twm_pipe;
    import fe_twm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_valid = 1'b0, i_sof = 1'b0, i_inv = 1'b0, i_ready = 1'b1;
    logic [3:0] i_idx = '0;
    logic [1:0][7:0] i_data = '0;
    logic o_ready_e, o_valid_e, o_sof_e, o_ready_c, o_valid_c, o_sof_c;
    logic [1:0][7:0] o_data_e, o_data_c;

    always #5 clk = ~clk;

    fe_twm_pipe #(.NS(16), .NBW_IN(8), .NBI_IN(1), .NBW_OUT(8), .NBI_OUT(1), .NBW_CS(8),
                  .IDX_EXT(1), .RND_INF(0)) u_ext (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready_e), .i_sof(i_sof),
        .i_idx(i_idx), .i_inv(i_inv), .i_data(i_data), .o_valid(o_valid_e),
        .i_ready(i_ready), .o_sof(o_sof_e), .o_data(o_data_e));

    fe_twm_pipe #(.NS(16), .NBW_IN(8), .NBI_IN(1), .NBW_OUT(8), .NBI_OUT(1), .NBW_CS(8),
                  .IDX_EXT(0), .RND_INF(0)) u_cnt (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready_c), .i_sof(i_sof),
        .i_idx(i_idx), .i_inv(i_inv), .i_data(i_data), .o_valid(o_valid_c),
        .i_ready(i_ready), .o_sof(o_sof_c), .o_data(o_data_c));

    bit sel = 1'b0;
    logic o_ready_s, o_valid_s, o_sof_s;
    logic [15:0] o_data_s;
    assign o_ready_s = sel ? o_ready_c : o_ready_e;
    assign o_valid_s = sel ? o_valid_c : o_valid_e;
    assign o_sof_s   = sel ? o_sof_c   : o_sof_e;
    assign o_data_s  = sel ? o_data_c  : o_data_e;

    int checks = 0, failures = 0, n_out = 0;
    logic [16:0] exp_q[$];
    logic [16:0] cur_exp = '0;
    logic [15:0] prev_data = '0, last_out = '0;
    bit accepted = 1'b0, out_seen = 1'b0, stall_prev = 1'b0;
    int exp16[16] = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 1, 2, 3, 0, 3, 6, 9};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] red(input int p);
        int r;
        r = (p + 64) >>> 7;
        if (r > 127) r = 127;
        if (r < -127) r = -127;
        return 8'(r);
    endfunction

    // Reference: W^e = cos - j sin with coefficients rounded to Q1.7
    function automatic logic [15:0] model(input int xi, input int xq, input int e, input bit inv);
        real th;
        int c, s, pi_, pq;
        th = 2.0 * 3.141592653589793 * real'(e) / 16.0;
        c = $rtoi($floor($cos(th) * 128.0 + 0.5));
        s = $rtoi($floor($sin(th) * 128.0 + 0.5));
        if (inv) s = -s;
        pi_ = xi * c + xq * s;
        pq  = xq * c - xi * s;
        return {red(pq), red(pi_)};
    endfunction

    task automatic step();
        logic [16:0] got;
        #1;
        accepted = i_valid && o_ready_s;
        out_seen = o_valid_s && i_ready;
        if (stall_prev) begin
            chk("hold_valid", 32'(o_valid_s), 1);
            chk("hold_data", 32'(o_data_s), 32'(prev_data));
        end
        if (out_seen) begin
            n_out++;
            last_out = o_data_s;
            if (exp_q.size() == 0) chk("spurious_out", 1, 0);
            else begin
                got = exp_q.pop_front();
                chk("sb_data", 32'(o_data_s), 32'(got[15:0]));
                chk("sb_sof", 32'(o_sof_s), 32'(got[16]));
            end
        end
        if (accepted) exp_q.push_back(cur_exp);
        stall_prev = o_valid_s && !i_ready;
        if (stall_prev) begin
            chk("stall_ready", 32'(o_ready_s), 0);
            prev_data = o_data_s;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int xi, input int xq, input int idx, input int e,
                          input bit inv, input bit sof);
        i_valid = 1'b1;
        i_data[IDX_I] = 8'(xi);
        i_data[IDX_Q] = 8'(xq);
        i_idx = 4'(idx);
        i_inv = inv;
        i_sof = sof;
        cur_exp = {sof, model(xi, xq, e, inv)};
    endtask

    task automatic put(input int xi, input int xq, input int idx, input int e,
                       input bit inv, input bit sof);
        set_in(xi, xq, idx, e, inv, sof);
        accepted = 1'b0;
        for (int t = 0; t < 20 && !accepted; t++) step();
        if (!accepted) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        i_valid = 1'b0;
        i_sof = 1'b0;
        for (int t = 0; t < 40 && exp_q.size() > 0; t++) step();
        if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 0);
    endtask

    initial begin
        int lat, n0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid_e", 32'(o_valid_e), 0);
        chk("rst_sof_e", 32'(o_sof_e), 0);
        chk("rst_data_e", 32'(o_data_e), 0);
        chk("rst_ready_e", 32'(o_ready_e), 1);
        chk("rst_valid_c", 32'(o_valid_c), 0);
        chk("rst_data_c", 32'(o_data_c), 0);

        // external index, 0 degrees, latency
        put(64, -32, 0, 0, 1'b0, 1'b0);
        i_valid = 1'b0;
        lat = 0;
        for (int t = 0; t < 12; t++) begin
            step();
            lat++;
            if (out_seen) break;
        end
        chk("t1_latency", 32'(lat), 4);
        chk("t1_data", 32'(last_out), 32'({8'hE0, 8'h40}));

        put(64, -32, 4, 4, 1'b0, 1'b0);   drain();
        chk("t2_90", 32'(last_out), 32'({8'hC0, 8'hE0}));
        put(64, -32, 4, 4, 1'b1, 1'b0);   drain();
        chk("t2_90_inv", 32'(last_out), 32'({8'h40, 8'h20}));
        put(64, -32, 12, 12, 1'b0, 1'b0); drain();
        chk("t2_270", 32'(last_out), 32'({8'h40, 8'h20}));
        put(100, 0, 2, 2, 1'b0, 1'b0);    drain();
        chk("t3_45", 32'(last_out), 32'({8'hB9, 8'h47}));
        put(100, 0, 2, 2, 1'b1, 1'b0);    drain();
        chk("t3_45_inv", 32'(last_out), 32'({8'h47, 8'h47}));
        put(-128, 0, 8, 8, 1'b0, 1'b0);   drain();
        chk("t4_sat", 32'(last_out), 32'({8'h00, 8'h7F}));

        // stream with a 3-cycle downstream stall
        n0 = n_out;
        for (int k = 0; k < 8; k++) begin
            if (k == 5) begin
                set_in(-100 + 27 * k, 90 - 23 * k, (3 * k + 1) % 16, (3 * k + 1) % 16, k[0], 1'b0);
                i_ready = 1'b0;
                repeat (3) step();
                i_ready = 1'b1;
            end
            put(-100 + 27 * k, 90 - 23 * k, (3 * k + 1) % 16, (3 * k + 1) % 16, k[0], 1'b0);
        end
        drain();
        chk("t5_count", 32'(n_out - n0), 8);

        // internal frame counter: two full frames
        sel = 1'b1;
        for (int k = 0; k < 32; k++)
            put(-100 + 6 * k, 70 - 4 * k, 0, exp16[k % 16], 1'b0, (k % 16) == 0);
        drain();

        // i_sof mid-frame restarts the exponent sequence
        for (int k = 0; k < 5; k++) put(30 + k, -40 + 9 * k, 0, exp16[k], 1'b0, k == 0);
        for (int k = 0; k < 8; k++) put(-60 + 11 * k, 50 - k, 0, exp16[k], 1'b1, k == 0);
        drain();

        // reset mid-frame discards in-flight samples
        for (int k = 0; k < 3; k++) put(20 * k, 10, 0, exp16[k], 1'b0, k == 0);
        i_valid = 1'b0;
        i_sof = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_valid_c", 32'(o_valid_c), 0);
        chk("rst_mid_valid_e", 32'(o_valid_e), 0);
        chk("rst_mid_sof_c", 32'(o_sof_c), 0);
        exp_q.delete();
        stall_prev = 1'b0;
        put(77, -33, 0, 0, 1'b0, 1'b1);
        put(77, -33, 0, 0, 1'b0, 1'b0);
        drain();
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
